dct_term_accumulator: RTL

- Downstream consumer of the 8x16 shift-add fractional multiplier, whose product is 24-bit Q8.16.
- Sign-applies and sums N consecutive products (one DCT basis dot product), rounds the Q.16 sum to an integer, saturates it, and emits one signed coefficient per group.
- Valid/ready on both sides; a single output holding register.

---
 rtl/dct_pkg.sv | 31 +++
 rtl/dct_term_accumulator_if.sv | 33 +++
 rtl/dct_round_sat.sv | 12 +
 rtl/dct_term_accumulator.sv | 72 +++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared DCT datapath constants plus the round-half-up / clamp helper used by
// the accumulator and the later quantisation stages.
package dct_pkg;

    localparam int PROD_W  = 24;
    localparam int FRAC_W  = 16;
    localparam int N_TERMS = 8;
    localparam int OUT_W   = 12;

    localparam int ACC_W = PROD_W + $clog2(N_TERMS) + 1;
    localparam int RND_W = ACC_W - FRAC_W + 1;

    localparam logic signed [ACC_W:0]   HALF_LSB = (ACC_W + 1)'(2 ** (FRAC_W - 1));
    localparam logic signed [RND_W-1:0] SAT_MAX  = RND_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [RND_W-1:0] SAT_MIN  = RND_W'(-(2 ** (OUT_W - 1)));

    // One guard bit on the bias add so the +0.5 can never wrap the sum.
    function automatic logic signed [OUT_W-1:0] sat_round(input logic signed [ACC_W-1:0] sum);
        logic signed [ACC_W:0]   biased;
        logic signed [RND_W-1:0] r;
        biased = {sum[ACC_W-1], sum} + HALF_LSB;
        r      = biased[ACC_W:FRAC_W];
        if (r > SAT_MAX) begin
            return SAT_MAX[OUT_W-1:0];
        end else if (r < SAT_MIN) begin
            return SAT_MIN[OUT_W-1:0];
        end
        return r[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/dct_term_accumulator_if.sv
// Product-beat input and coefficient output handshakes of the term accumulator.
// Master is the producer/consumer side, slave is the accumulator.
interface dct_term_accumulator_if;

    logic                       in_valid;
    logic                       in_ready;
    logic [dct_pkg::PROD_W-1:0] in_prod;
    logic                       in_neg;
    logic                       out_valid;
    logic                       out_ready;
    logic [dct_pkg::OUT_W-1:0]  out_coef;

    modport master (
        output in_valid,
        output in_prod,
        output in_neg,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_coef
    );

    modport slave (
        input  in_valid,
        input  in_prod,
        input  in_neg,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_coef
    );

endinterface

// File: rtl/dct_round_sat.sv
// Combinational Q.16 -> integer round-half-up and clamp to the coefficient range.
// Zero latency, no handshake.
module dct_round_sat
    import dct_pkg::*;
(
    input  logic signed [ACC_W-1:0] sum,
    output logic signed [OUT_W-1:0] coef
);

    assign coef = sat_round(sum);

endmodule

// File: rtl/dct_term_accumulator.sv
// Signed sum of N_TERMS Q8.16 products, rounded and saturated to one coefficient.
// Result registered 1 cycle after the final beat; only the final beat stalls on a full output register.
module dct_term_accumulator
    import dct_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    dct_term_accumulator_if.slave   bus,
    output logic                    busy
);

    localparam int               CNT_W    = $clog2(N_TERMS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc;
    logic [ACC_W-1:0]        mag;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] sum;
    logic signed [OUT_W-1:0] coef_rnd;
    logic signed [OUT_W-1:0] out_coef_q;
    logic                    out_valid_q;
    logic                    last_beat;
    logic                    accept;

    assign mag       = {{(ACC_W - PROD_W){1'b0}}, bus.in_prod};
    assign term      = bus.in_neg ? -$signed(mag) : $signed(mag);
    assign sum       = acc + term;
    assign last_beat = (cnt == LAST_CNT);

    // A pending coefficient only blocks the beat that would overwrite it.
    assign bus.in_ready = !(last_beat && out_valid_q && !bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    dct_round_sat u_round_sat (
        .sum  (sum),
        .coef (coef_rnd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            acc         <= '0;
            out_valid_q <= 1'b0;
            out_coef_q  <= '0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (clear) begin
                cnt <= '0;
                acc <= '0;
            end else if (accept) begin
                if (last_beat) begin
                    cnt         <= '0;
                    acc         <= '0;
                    out_coef_q  <= coef_rnd;
                    out_valid_q <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                    acc <= sum;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_coef  = out_coef_q;
    assign busy          = (cnt != '0);

endmodule
